adc_scan_scheduler: RTL

Multi-channel conversion scheduler that sequences the single-channel ADC communicator. On a periodic tick or a software single-shot, it walks the enabled channels in ascending order. For each channel it drives the analog mux select, waits a settle time, issues a one-cycle convert request, waits for conversion done, strobes the ADC read line and publishes the sample with its channel tag.

---
 rtl/adc_scan_scheduler_if.sv | 37 +++
 rtl/adc_scan_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler_if.sv
// ADC communicator and result bus between the scan scheduler and its peers.
// master = scheduler side, slave = ADC/consumer side.
interface adc_scan_scheduler_if #(
   parameter int CH_W   = 2,
   parameter int DATA_W = 8
);
   logic              convert;
   logic              adc_done;
   logic [DATA_W-1:0] adc_data;
   logic [CH_W-1:0]   ch_sel;
   logic              rd_n;
   logic [DATA_W-1:0] result_data;
   logic [CH_W-1:0]   result_ch;
   logic              result_valid;

   modport master (
      output convert,
      output ch_sel,
      output rd_n,
      output result_data,
      output result_ch,
      output result_valid,
      input  adc_done,
      input  adc_data
   );

   modport slave (
      input  convert,
      input  ch_sel,
      input  rd_n,
      input  result_data,
      input  result_ch,
      input  result_valid,
      output adc_done,
      output adc_data
   );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Multi-channel ADC scan scheduler: periodic or single-shot scans over a
// snapshotted channel mask, sequencing settle, convert, wait and read.
module adc_scan_scheduler #(
   parameter int NUM_CH        = 4,
   parameter int CH_W          = 2,
   parameter int DATA_W        = 8,
   parameter int SETTLE_CYCLES = 8,
   parameter int RD_CYCLES     = 2,
   parameter int TIMEOUT       = 64,
   parameter int PERIOD_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic                single_shot,
   adc_scan_scheduler_if.master bus,
   output logic                scan_done,
   output logic                busy,
   output logic                timeout_err,
   output logic                overrun
);

   localparam int CNT_W =
      $clog2(TIMEOUT + SETTLE_CYCLES + RD_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CONVERT,
      WAIT_DONE,
      READ,
      NEXT
   } state_t;

   state_t              state, state_nx;
   logic [PERIOD_W-1:0] per_cnt;
   logic [PERIOD_W-1:0] per_last;
   logic                tick;
   logic                trig;
   logic [NUM_CH-1:0]   mask_q;
   logic                load_mask;
   logic [CH_W-1:0]     ch_q, ch_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                tmo_q, tmo_nx;
   logic                cap;
   logic [DATA_W-1:0]   res_data_q;
   logic [CH_W-1:0]     res_ch_q;
   logic [CH_W:0]       first_hit;
   logic [CH_W:0]       next_hit;
   logic                convert_c;
   logic                rd_n_c;
   logic                valid_c;

   // Lowest set bit of m at or above index from; MSB flags a hit.
   function automatic logic [CH_W:0] find_from(
      input logic [NUM_CH-1:0] m,
      input int                from
   );
      logic [CH_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) begin
            r = {1'b1, CH_W'(i)};
         end
      end
      return r;
   endfunction

   assign first_hit = find_from(ch_mask, 0);
   assign next_hit  = find_from(mask_q, int'(ch_q) + 1);

   // period of 0 behaves as 1: terminal value 0, tick every cycle
   assign per_last = (period == '0) ? '0
                   : period - PERIOD_W'(1);
   assign tick = enable && (per_cnt == per_last);
   assign trig = (enable & tick) | single_shot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
      end else if (!enable || tick) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch_q       <= '0;
         cnt        <= '0;
         tmo_q      <= 1'b0;
         mask_q     <= '0;
         res_data_q <= '0;
         res_ch_q   <= '0;
      end else begin
         state <= state_nx;
         ch_q  <= ch_nx;
         cnt   <= cnt_nx;
         tmo_q <= tmo_nx;
         if (load_mask) begin
            mask_q <= ch_mask;
         end
         if (cap) begin
            res_data_q <= bus.adc_data;
            res_ch_q   <= ch_q;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      ch_nx       = ch_q;
      cnt_nx      = cnt;
      tmo_nx      = tmo_q;
      load_mask   = 1'b0;
      cap         = 1'b0;
      convert_c   = 1'b0;
      rd_n_c      = 1'b1;
      valid_c     = 1'b0;
      scan_done   = 1'b0;
      timeout_err = 1'b0;
      unique case (state)
         IDLE: begin
            if (trig && (ch_mask != '0)) begin
               load_mask = 1'b1;
               ch_nx     = first_hit[CH_W-1:0];
               cnt_nx    = '0;
               state_nx  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_nx   = '0;
               state_nx = CONVERT;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         CONVERT: begin
            convert_c = 1'b1;
            cnt_nx    = '0;
            tmo_nx    = 1'b0;
            state_nx  = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.adc_done) begin
               cnt_nx   = '0;
               state_nx = READ;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               cnt_nx   = '0;
               tmo_nx   = 1'b1;
               state_nx = NEXT;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         READ: begin
            rd_n_c = 1'b0;
            if (cnt == CNT_W'(RD_CYCLES - 1)) begin
               cap      = 1'b1;
               cnt_nx   = '0;
               state_nx = NEXT;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         NEXT: begin
            valid_c     = !tmo_q;
            timeout_err = tmo_q;
            cnt_nx      = '0;
            if (next_hit[CH_W]) begin
               ch_nx    = next_hit[CH_W-1:0];
               state_nx = SETTLE;
            end else begin
               scan_done = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Strobes decode from the async-reset state so they drop with rst_n.
   assign busy    = (state != IDLE);
   assign overrun = busy && trig;

   assign bus.convert      = convert_c;
   assign bus.rd_n         = rd_n_c;
   assign bus.ch_sel       = ch_q;
   assign bus.result_valid = valid_c;
   assign bus.result_data  = res_data_q;
   assign bus.result_ch    = res_ch_q;

endmodule
